// File: rtl/ssif_pkg.sv
// Shared types and constants for the serial response interface.
package ssif_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DECODE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [7:0] READ_CMD  = 8'hAA;
  localparam logic [7:0] WRITE_CMD = 8'h0C;

  localparam int CMD_BITS = 8;
  localparam int RD_BITS  = 10;
  localparam int WR_BITS  = 8;

  localparam logic [3:0] CMD_LAST = 4'(CMD_BITS - 1);
  localparam logic [3:0] RD_LAST  = 4'(RD_BITS - 1);
  localparam logic [3:0] WR_LAST  = 4'(WR_BITS - 1);

  // Bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/serial_resp_if_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL is the idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_resp_if.sv
// Serial command/response slave: 8-bit command, then 10-bit read or 8-bit write payload.
// Optional sticky error flags err_abort/err_cmd are built when SSIF_ERR_DETECT_EN is defined.
module serial_resp_if
  import ssif_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
`ifdef SSIF_ERR_DETECT_EN
  output logic       err_abort,
  output logic       err_cmd,
`endif
  input  logic       tclk,
  input  logic       trst,
  input  logic       dq_in,
  output logic       dq_out,
  output logic       dq_oe,
  input  logic [9:0] rd_data,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       busy
);

  logic       tclk_s;
  logic       trst_s;
  logic       dq_s;
  logic       tclk_q;
  logic [1:0] flushed;
  logic       armed;
  logic       tclk_rise;
  logic       tclk_fall;
  state_t     state;
  logic [3:0] cnt;
  logic [7:0] cmd_sr;
  logic [7:0] wr_sr;
  logic [9:0] rd_sr;

  sync2 #(.RST_VAL(1'b1)) u_sync_tclk (.clk(clk), .rst_n(rst_n), .d(tclk),  .q(tclk_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_trst (.clk(clk), .rst_n(rst_n), .d(trst),  .q(trst_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_dq   (.clk(clk), .rst_n(rst_n), .d(dq_in), .q(dq_s));

  assign tclk_rise = tclk_s & ~tclk_q;
  assign tclk_fall = ~tclk_s & tclk_q;
  assign busy      = trst_s;

  // The synchronizer output is only trusted once its reset value has flushed;
  // a frame is joined only after trst has genuinely been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tclk_q  <= 1'b1;
      flushed <= 2'b00;
      armed   <= 1'b0;
    end else begin
      tclk_q  <= tclk_s;
      flushed <= {flushed[0], 1'b1};
      if (flushed[1] && !trst_s)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cmd_sr    <= 8'd0;
      wr_sr     <= 8'd0;
      rd_sr     <= 10'd0;
      cmd       <= 8'd0;
      cmd_valid <= 1'b0;
      wr_data   <= 8'd0;
      wr_valid  <= 1'b0;
      dq_out    <= 1'b0;
      dq_oe     <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      wr_valid  <= 1'b0;
      if (!trst_s) begin
        state  <= IDLE;
        cnt    <= 4'd0;
        dq_oe  <= 1'b0;
        dq_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (armed) begin
              state <= CMD;
              cnt   <= 4'd0;
            end
          end
          CMD: begin
            if (tclk_rise) begin
              cmd_sr <= {dq_s, cmd_sr[7:1]};
              cnt    <= sat_inc(cnt);
              if (cnt == CMD_LAST)
                state <= DECODE;
            end
          end
          DECODE: begin
            cmd       <= cmd_sr;
            cmd_valid <= 1'b1;
            cnt       <= 4'd0;
            if (cmd_sr == READ_CMD) begin
              rd_sr <= rd_data;
              state <= READ;
            end else if (cmd_sr == WRITE_CMD) begin
              state <= WRITE;
            end else begin
              state <= DONE;
            end
          end
          READ: begin
            // A bit is counted only on the rising edge that closes a presented bit.
            if (tclk_fall) begin
              dq_oe  <= 1'b1;
              dq_out <= rd_sr[0];
              rd_sr  <= {1'b0, rd_sr[9:1]};
            end else if (tclk_rise && dq_oe) begin
              cnt <= sat_inc(cnt);
              if (cnt == RD_LAST) begin
                dq_oe <= 1'b0;
                state <= DONE;
              end
            end
          end
          WRITE: begin
            if (tclk_rise) begin
              wr_sr <= {dq_s, wr_sr[7:1]};
              cnt   <= sat_inc(cnt);
              if (cnt == WR_LAST) begin
                wr_data  <= {dq_s, wr_sr[7:1]};
                wr_valid <= 1'b1;
                state    <= DONE;
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SSIF_ERR_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_abort <= 1'b0;
      err_cmd   <= 1'b0;
    end else begin
      if (!trst_s && (state == CMD || state == READ || state == WRITE))
        err_abort <= 1'b1;
      if (trst_s && state == DECODE && cmd_sr != READ_CMD && cmd_sr != WRITE_CMD)
        err_cmd <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/serial_resp_if.md
SERIAL_RESP_IF -- requirements
Module: serial_resp_if

Interface
REQ-001 The block SHALL have port clk, input, 1, single system clock; all flops rise on clk.
REQ-002 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port tclk, input, 1, serial clock from the host; idles high; asynchronous to clk.
REQ-004 The block SHALL have port trst, input, 1, frame enable from the host; low means the frame is reset or idle.
REQ-005 The block SHALL have port dq_in, input, 1, serial data driven by the host.
REQ-006 The block SHALL have port dq_out, output, 1, serial read data driven toward the host.
REQ-007 The block SHALL have port dq_oe, output, 1, tristate enable for dq_out.
REQ-008 The block SHALL have port rd_data, input, 10, read value returned to the host, LSB first.
REQ-009 The block SHALL have port cmd, output, 8, last received command byte.
REQ-010 The block SHALL have port cmd_valid, output, 1, one-clk pulse when cmd is updated.
REQ-011 The block SHALL have port wr_data, output, 8, payload of a write command.
REQ-012 The block SHALL have port wr_valid, output, 1, one-clk pulse when wr_data is updated.
REQ-013 The block SHALL have port busy, output, 1, high while a frame is in progress (trst high).

Function
REQ-014 The block SHALL pass tclk, trst and dq_in through 2-flop synchronizers, then detect tclk edges from the synchronized value and its previous value; clk SHALL be at least 8x the tclk bit rate.
REQ-015 The FSM SHALL have the states IDLE, CMD, DECODE, READ, WRITE and DONE.
REQ-016 IDLE -> CMD: synchronized trst rises; the bit counter is cleared.
REQ-017 CMD: on each tclk rising edge, the block SHALL shift dq_in into the command register LSB first; after the 8th bit it SHALL go to DECODE.
REQ-018 DECODE (1 clk): the block SHALL update cmd and pulse cmd_valid, then branch:
- READ_CMD (0xAA) -> READ, and capture rd_data into the shift register in the same clk.
- WRITE_CMD (0x0C) -> WRITE.
- any other value -> DONE.
REQ-019 READ: on each tclk falling edge, the block SHALL assert dq_oe and present the next bit LSB first on dq_out, held until the next falling edge. After the 10th bit's tclk rising edge it SHALL deassert dq_oe and go to DONE.
REQ-020 WRITE: on each of 8 tclk rising edges, the block SHALL shift dq_in into wr_data LSB first. It SHALL then pulse wr_valid for 1 clk and go to DONE.
REQ-021 DONE: the block SHALL ignore tclk edges and return to IDLE when synchronized trst falls.
REQ-022 Synchronized trst low in any state SHALL force IDLE on the next clk, with dq_oe=0 and no cmd_valid/wr_valid pulse. Partially received bits SHALL be discarded.
REQ-023 dq_oe SHALL never be high outside READ.
REQ-024 The bit counter SHALL be 4 bits wide and SHALL saturate rather than wrap.
REQ-025 busy SHALL equal synchronized trst.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state IDLE
- dq_oe=0, dq_out=0
- cmd=0, wr_data=0
- cmd_valid=0, wr_valid=0, busy=0
- synchronizer flops: tclk=1, trst=0, dq=0
REQ-027 After rst_n deasserts, a frame already in progress (trst high) SHALL NOT be joined; the block SHALL wait for trst low and then high again.

Configuration
REQ-028 With SSIF_ERR_DETECT_EN defined, the block SHALL add output err_abort (1 bit, sticky) and output err_cmd (1 bit, sticky):
- err_abort is set when trst falls in CMD, READ or WRITE.
- err_cmd is set when DECODE sees an unknown command.
- Both are cleared only by rst_n.
REQ-029 Without SSIF_ERR_DETECT_EN, the block SHALL have neither port nor any associated logic; all other behaviour SHALL be identical.

Structure
REQ-030 Package ssif_pkg SHALL hold:
- the state enum
- READ_CMD=8'hAA, WRITE_CMD=8'h0C
- CMD_BITS=8, RD_BITS=10, WR_BITS=8
REQ-031 The 2-flop synchronizer SHALL be a sub-module sync2 with a reset-value parameter, instantiated three times.

Verification
REQ-032 Reset: rst_n low mid-READ -> dq_oe=0 and state IDLE immediately; no pulses.
REQ-033 Read: frame with cmd 0xAA, rd_data=10'h2B5 -> cmd_valid pulse with cmd=0xAA; host samples 1,0,1,0,1,1,0,1,0,1 on the 10 tclk-low phases; dq_oe low after the 10th bit.
REQ-034 Write: cmd 0x0C then payload 0x5A -> one cmd_valid pulse, then one wr_valid pulse with wr_data=0x5A; dq_oe never high.
REQ-035 Unknown command 0x33 -> cmd_valid with cmd=0x33, no dq drive, DONE until trst low; err_cmd=1 when SSIF_ERR_DETECT_EN is defined.
REQ-036 Abort: trst dropped after 4 command bits -> IDLE; cmd unchanged; no pulses; err_abort=1 when SSIF_ERR_DETECT_EN is defined. The next full 0xAA frame SHALL then work correctly.
REQ-037 Back-to-back: two read frames separated by 2 tclk periods with trst low -> both return correct data; busy tracks trst with 2-3 clk latency.
